// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, controller states
// and the mode-register helper shared by the controller.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111,
    CMD_DESEL     = 4'b1111
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MODE,
    ST_IDLE,
    ST_ACTIVATE,
    ST_RW,
    ST_PRECHARGE_WAIT,
    ST_REFRESH
  } sdram_state_e;

  // Burst length 1, sequential, programmed CAS latency, burst writes off.
  function automatic logic [15:0] sdram_mode(input logic [2:0] cl);
    logic [15:0] m;
    m      = '0;
    m[6:4] = cl;
    return m;
  endfunction

endpackage

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-port SDR SDRAM controller with power-up init,
// auto-refresh and single-word accesses using auto-precharge.
module sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS   = 24,
  parameter int DATA_BITS   = 16,
  parameter int BANK_BITS   = 2,
  parameter int ROW_BITS    = 13,
  parameter int COL_BITS    = 9,
  parameter int CAS_LATENCY = 2,
  parameter int T_INIT      = 20000,
  parameter int T_RP        = 2,
  parameter int T_RCD       = 2,
  parameter int T_RFC       = 7,
  parameter int T_MRD       = 2,
  parameter int T_WR        = 2,
  parameter int T_REFI      = 780
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_buf,
  input  logic                   write_buf,
  input  logic [ADDR_BITS-1:0]   address,
  input  logic [DATA_BITS-1:0]   data_write,
  input  logic                   refresh_buf,
  output logic [DATA_BITS-1:0]   data_read,
  output logic                   busy,
  output logic                   sdram_cke,
  output logic                   sdram_cs_n,
  output logic                   sdram_ras_n,
  output logic                   sdram_cas_n,
  output logic                   sdram_we_n,
  output logic [BANK_BITS-1:0]   sdram_ba,
  output logic [ROW_BITS-1:0]    sdram_addr,
  output logic [DATA_BITS/8-1:0] sdram_dqm,
  output logic [DATA_BITS-1:0]   sdram_dq_o,
  output logic                   sdram_dq_oe,
  input  logic [DATA_BITS-1:0]   sdram_dq_i
);

  localparam int CW      = $clog2(T_INIT + 1);
  localparam int FW      = $clog2(T_REFI + 1);
  localparam int ROW_LO  = COL_BITS;
  localparam int BANK_LO = COL_BITS + ROW_BITS;
  localparam logic [15:0] MODE = sdram_mode(3'(CAS_LATENCY));

  sdram_state_e r_state, w_nstate;
  sdram_cmd_e   r_cmd, w_cmd;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [FW-1:0] r_refcnt;

  logic [BANK_BITS-1:0] r_ba, w_ba, r_bank;
  logic [ROW_BITS-1:0]  r_addr, w_addr, r_row, w_cas_addr;
  logic [COL_BITS-1:0]  r_col;
  logic [DATA_BITS-1:0] r_wdata, r_dq_o, r_data_read;
  logic [DATA_BITS/8-1:0] r_dqm;

  logic r_cke, r_oe, r_busy, r_ready;
  logic r_rd_d, r_wr_d, r_req_wr, r_req_pend, r_ref_pend;
  logic w_oe, w_busy, w_cap, w_latch, w_pend_set, w_pend_clr;
  logic w_ref_go, w_init_done, w_zero;
  logic w_rd_edge, w_wr_edge, w_edge, w_ref_req;

  assign w_zero    = (r_cnt == '0);
  assign w_rd_edge = read_buf & ~r_rd_d;
  assign w_wr_edge = write_buf & ~r_wr_d;
  assign w_edge    = w_rd_edge | w_wr_edge;
  assign w_ref_req = r_ref_pend | refresh_buf | (r_refcnt == '0);

  always_comb begin
    w_cas_addr               = '0;
    w_cas_addr[COL_BITS-1:0] = r_col;
    w_cas_addr[10]           = 1'b1;
  end

  always_comb begin
    w_nstate    = r_state;
    w_ncnt      = w_zero ? '0 : r_cnt - CW'(1);
    w_cmd       = CMD_NOP;
    w_ba        = r_ba;
    w_addr      = r_addr;
    w_oe        = 1'b0;
    w_busy      = r_busy;
    w_cap       = 1'b0;
    w_latch     = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_ref_go    = 1'b0;
    w_init_done = 1'b0;
    unique case (r_state)
      ST_INIT_WAIT: if (w_zero) begin
        w_cmd      = CMD_PRECHARGE;
        w_ba       = '0;
        w_addr     = '0;
        w_addr[10] = 1'b1;
        w_nstate   = ST_INIT_PRE;
        w_ncnt     = CW'(T_RP - 1);
      end
      ST_INIT_PRE: if (w_zero) begin
        w_cmd    = CMD_REFRESH;
        w_nstate = ST_INIT_REF1;
        w_ncnt   = CW'(T_RFC - 1);
      end
      ST_INIT_REF1: if (w_zero) begin
        w_cmd    = CMD_REFRESH;
        w_nstate = ST_INIT_REF2;
        w_ncnt   = CW'(T_RFC - 1);
      end
      ST_INIT_REF2: if (w_zero) begin
        w_cmd    = CMD_LOAD_MODE;
        w_ba     = '0;
        w_addr   = MODE[ROW_BITS-1:0];
        w_nstate = ST_INIT_MODE;
        w_ncnt   = CW'(T_MRD - 1);
      end
      ST_INIT_MODE: if (w_zero) begin
        w_nstate    = ST_IDLE;
        w_busy      = 1'b0;
        w_init_done = 1'b1;
      end
      ST_IDLE: begin
        w_latch = w_edge;
        // Refresh wins; a request seen this cycle waits behind it.
        if (w_ref_req) begin
          w_cmd      = CMD_REFRESH;
          w_nstate   = ST_REFRESH;
          w_ncnt     = CW'(T_RFC - 1);
          w_busy     = 1'b1;
          w_ref_go   = 1'b1;
          w_pend_set = w_edge;
        end else if (w_edge) begin
          w_cmd    = CMD_ACTIVE;
          w_ba     = address[BANK_LO +: BANK_BITS];
          w_addr   = address[ROW_LO +: ROW_BITS];
          w_nstate = ST_ACTIVATE;
          w_ncnt   = CW'(T_RCD - 1);
          w_busy   = 1'b1;
        end
      end
      ST_REFRESH: if (w_zero) begin
        if (r_req_pend) begin
          w_cmd      = CMD_ACTIVE;
          w_ba       = r_bank;
          w_addr     = r_row;
          w_nstate   = ST_ACTIVATE;
          w_ncnt     = CW'(T_RCD - 1);
          w_pend_clr = 1'b1;
        end else begin
          w_nstate = ST_IDLE;
          w_busy   = 1'b0;
        end
      end
      ST_ACTIVATE: if (w_zero) begin
        w_ba     = r_bank;
        w_addr   = w_cas_addr;
        w_nstate = ST_RW;
        if (r_req_wr) begin
          w_cmd  = CMD_WRITE;
          w_oe   = 1'b1;
          w_ncnt = CW'(T_WR - 1);
        end else begin
          w_cmd  = CMD_READ;
          w_ncnt = CW'(CAS_LATENCY - 1);
        end
      end
      ST_RW: if (w_zero) begin
        w_nstate = ST_PRECHARGE_WAIT;
        w_ncnt   = r_req_wr ? CW'(T_RP) : '0;
      end
      ST_PRECHARGE_WAIT: if (w_zero) begin
        w_nstate = ST_IDLE;
        w_busy   = 1'b0;
        w_cap    = ~r_req_wr;
      end
      default: w_nstate = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT_WAIT;
      r_cnt   <= CW'(T_INIT);
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= CMD_DESEL;
      r_ba        <= '0;
      r_addr      <= '0;
      r_oe        <= 1'b0;
      r_dq_o      <= '0;
      r_cke       <= 1'b0;
      r_dqm       <= '1;
      r_busy      <= 1'b1;
      r_data_read <= '0;
      r_rd_d      <= 1'b0;
      r_wr_d      <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_pend  <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_wdata     <= '0;
    end else begin
      r_cmd  <= w_cmd;
      r_ba   <= w_ba;
      r_addr <= w_addr;
      r_oe   <= w_oe;
      r_cke  <= 1'b1;
      r_busy <= w_busy;
      r_rd_d <= read_buf;
      r_wr_d <= write_buf;
      if (w_oe)        r_dq_o      <= r_wdata;
      if (w_init_done) r_dqm       <= '0;
      if (w_cap)       r_data_read <= sdram_dq_i;
      if (w_latch) begin
        r_req_wr <= w_wr_edge & ~w_rd_edge;
        r_bank   <= address[BANK_LO +: BANK_BITS];
        r_row    <= address[ROW_LO +: ROW_BITS];
        r_col    <= address[COL_BITS-1:0];
        r_wdata  <= data_write;
      end
      if (w_pend_clr)      r_req_pend <= 1'b0;
      else if (w_pend_set) r_req_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_refcnt   <= FW'(T_REFI - 1);
      r_ref_pend <= 1'b0;
    end else begin
      if (w_init_done) r_ready <= 1'b1;
      if (w_ref_go || w_init_done)
        r_refcnt <= FW'(T_REFI - 1);
      else if (r_ready && r_refcnt != '0)
        r_refcnt <= r_refcnt - FW'(1);
      if (w_ref_go)
        r_ref_pend <= 1'b0;
      else if (r_ready && (refresh_buf || r_refcnt == '0))
        r_ref_pend <= 1'b1;
    end
  end

  assign data_read   = r_data_read;
  assign busy        = r_busy;
  assign sdram_cke   = r_cke;
  assign sdram_cs_n  = r_cmd[3];
  assign sdram_ras_n = r_cmd[2];
  assign sdram_cas_n = r_cmd[1];
  assign sdram_we_n  = r_cmd[0];
  assign sdram_ba    = r_ba;
  assign sdram_addr  = r_addr;
  assign sdram_dqm   = r_dqm;
  assign sdram_dq_o  = r_dq_o;
  assign sdram_dq_oe = r_oe;

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: directed bench with command/data scoreboards
// and a small single-word SDRAM model on the pins.
module tb_sdram_ctrl;

  localparam int T_INIT = 20000;
  localparam int T_RP   = 2;
  localparam int T_RCD  = 2;
  localparam int T_RFC  = 7;
  localparam int T_MRD  = 2;
  localparam int T_WR   = 2;
  localparam int T_REFI = 780;
  localparam int CL     = 2;

  localparam logic [3:0] C_LM  = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [19:0] cyc;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dq;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_buf = 1'b0;
  logic        write_buf = 1'b0;
  logic        refresh_buf = 1'b0;
  logic [23:0] address = '0;
  logic [15:0] data_write = '0;
  logic [15:0] data_read;
  logic        busy;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [1:0]  dqm;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [15:0] dq_i = 16'hBAD0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmd_t        mon_q[$];
  cmd_t        exp_q[$];
  logic [15:0] dat_q[$];

  logic [15:0] mem [logic [23:0]];
  logic [12:0] row_of [4];
  int          rd_due = -1;
  logic [23:0] rd_key = '0;

  sdram_ctrl #(
    .T_INIT(T_INIT), .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC),
    .T_MRD(T_MRD), .T_WR(T_WR), .T_REFI(T_REFI), .CAS_LATENCY(CL)
  ) dut (
    .clk(clk), .rst(rst),
    .read_buf(read_buf), .write_buf(write_buf),
    .address(address), .data_write(data_write),
    .refresh_buf(refresh_buf),
    .data_read(data_read), .busy(busy),
    .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm),
    .sdram_dq_o(dq_o), .sdram_dq_oe(dq_oe), .sdram_dq_i(dq_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Command monitor plus memory model; read data lands CL cycles after READ.
  always @(negedge clk) begin
    cmd_t m;
    logic [3:0] c;
    c = {cs_n, ras_n, cas_n, we_n};
    if ((!cs_n && c != C_NOP) || dq_oe) begin
      m = '0;
      m.cmd = c;
      m.cyc = 20'(cyc);
      if (c != C_REF) begin
        m.ba   = ba;
        m.addr = addr;
      end
      if (dq_oe) begin
        m.oe = 1'b1;
        m.dq = dq_o;
      end
      mon_q.push_back(m);
    end
    if (!cs_n && c == C_ACT) row_of[ba] = addr;
    if (!cs_n && c == C_WR) mem[{ba, row_of[ba], addr[8:0]}] = dq_o;
    if (!cs_n && c == C_RD) begin
      rd_due = cyc + CL;
      rd_key = {ba, row_of[ba], addr[8:0]};
    end
    if (cyc == rd_due)
      dq_i = mem.exists(rd_key) ? mem[rd_key] : 16'h0BAD;
    else
      dq_i = 16'hBAD0;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expc(input logic [3:0] c, input int at,
                      input logic [1:0] b, input logic [12:0] a,
                      input logic oe, input logic [15:0] d);
    cmd_t e;
    e.cmd = c;
    e.cyc = 20'(at);
    e.ba = b;
    e.addr = a;
    e.oe = oe;
    e.dq = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    cmd_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      chk(tag, 64'(g), 64'(e));
    end
    chk({tag, "_extra"}, 64'(mon_q.size()), 64'd0);
    mon_q.delete();
  endtask

  task automatic wait_low(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (busy === 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic exp_init(input int t0, output int idle);
    int p;
    p = t0 + T_INIT;
    expc(C_PRE, p, 2'd0, 13'h400, 1'b0, 16'h0);
    expc(C_REF, p + T_RP, 2'd0, 13'h0, 1'b0, 16'h0);
    expc(C_REF, p + T_RP + T_RFC, 2'd0, 13'h0, 1'b0, 16'h0);
    expc(C_LM, p + T_RP + 2 * T_RFC, 2'd0, 13'h020, 1'b0, 16'h0);
    idle = p + T_RP + 2 * T_RFC + T_MRD;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, idle, at, a, b, r, f, g;

    tick(3);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_data", 64'(data_read), 64'd0);
    chk("rst_cke", 64'(cke), 64'd0);
    chk("rst_cmd", 64'({cs_n, ras_n, cas_n, we_n}), 64'hF);
    chk("rst_baaddr", 64'({ba, addr}), 64'd0);
    chk("rst_dqm", 64'(dqm), 64'h3);
    chk("rst_oe", 64'(dq_oe), 64'd0);

    rst = 1'b0;
    t0 = cyc + 1;
    tick(1);
    chk("cke_rise", 64'(cke), 64'd1);
    exp_init(t0, idle);
    wait_low(T_INIT + 200, at);
    chk("init_idle", 64'(at), 64'(idle));
    drain("init");
    chk("dqm_run", 64'(dqm), 64'd0);

    // Write, with write_buf held high past completion.
    a = cyc;
    write_buf = 1'b1;
    address = 24'h12_3456;
    data_write = 16'hA5C3;
    expc(C_ACT, a + 1, 2'd0, 13'h091A, 1'b0, 16'h0);
    expc(C_WR, a + 3, 2'd0, 13'h456, 1'b1, 16'hA5C3);
    tick(1);
    chk("wr_busy_hi", 64'(busy), 64'd1);
    wait_low(50, at);
    chk("wr_done", 64'(at), 64'(a + 1 + T_RCD + T_WR + T_RP + 1));
    tick(3);
    write_buf = 1'b0;
    tick(1);
    drain("wr");
    chk("wr_hold_data", 64'(data_read), 64'd0);

    // Simultaneous read and write edges: only the read runs.
    b = cyc;
    read_buf = 1'b1;
    write_buf = 1'b1;
    data_write = 16'h1111;
    expc(C_ACT, b + 1, 2'd0, 13'h091A, 1'b0, 16'h0);
    expc(C_RD, b + 3, 2'd0, 13'h456, 1'b0, 16'h0);
    dat_q.push_back(16'hA5C3);
    wait_low(50, at);
    chk("rd_done", 64'(at), 64'(b + 1 + T_RCD + CL + 1));
    chk("rd_data", 64'(data_read), 64'(dat_q.pop_front()));
    read_buf = 1'b0;
    write_buf = 1'b0;
    tick(2);
    drain("rd");

    // Periodic refresh, then a 2000-cycle idle window.
    r = idle + T_REFI;
    expc(C_REF, r, 2'd0, 13'h0, 1'b0, 16'h0);
    for (int i = 0; i < 1000 && mon_q.size() == 0; i++) tick(1);
    drain("ref0");
    expc(C_REF, r + T_REFI, 2'd0, 13'h0, 1'b0, 16'h0);
    expc(C_REF, r + 2 * T_REFI, 2'd0, 13'h0, 1'b0, 16'h0);
    while (cyc < r + 2000) tick(1);
    drain("ref_idle");
    chk("idle_hold_data", 64'(data_read), 64'hA5C3);

    // Forced refresh and read edge in the same cycle.
    f = cyc;
    refresh_buf = 1'b1;
    read_buf = 1'b1;
    expc(C_REF, f + 1, 2'd0, 13'h0, 1'b0, 16'h0);
    expc(C_ACT, f + 1 + T_RFC, 2'd0, 13'h091A, 1'b0, 16'h0);
    expc(C_RD, f + 1 + T_RFC + T_RCD, 2'd0, 13'h456, 1'b0, 16'h0);
    dat_q.push_back(16'hA5C3);
    tick(1);
    refresh_buf = 1'b0;
    read_buf = 1'b0;
    wait_low(50, at);
    chk("frc_done", 64'(at), 64'(f + T_RFC + 1 + T_RCD + CL + 1));
    chk("frc_data", 64'(data_read), 64'(dat_q.pop_front()));
    tick(1);
    drain("frc");

    // Reset while the read sits in RW.
    g = cyc;
    read_buf = 1'b1;
    expc(C_ACT, g + 1, 2'd0, 13'h091A, 1'b0, 16'h0);
    expc(C_RD, g + 3, 2'd0, 13'h456, 1'b0, 16'h0);
    tick(1);
    read_buf = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_cke", 64'(cke), 64'd0);
    chk("abort_data", 64'(data_read), 64'd0);
    chk("abort_cmd", 64'({cs_n, ras_n, cas_n, we_n}), 64'hF);
    chk("abort_dqm", 64'(dqm), 64'h3);
    rst = 1'b0;
    t0 = cyc + 1;
    drain("abort");
    exp_init(t0, idle);
    wait_low(T_INIT + 200, at);
    chk("reinit_idle", 64'(at), 64'(idle));
    drain("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl.md
# sdram_ctrl

Single-port SDR SDRAM controller on the consumer side of `sdram_bus` (host modport), in the SDRAM clock domain. It takes the already-synchronised read, write and refresh strobes plus address and data from the bus. It runs the power-up init sequence, periodic and forced auto-refresh, and single-word accesses with auto-precharge. It drives the SDRAM command and address pins and returns `data_read` and `busy` to the bus.

## Interface
- `ADDR_BITS`, 24: host word address width; must equal `BANK_BITS+ROW_BITS+COL_BITS`.
- `DATA_BITS`, 16: data word / DQ width.
- `BANK_BITS`, 2; `ROW_BITS`, 13; `COL_BITS`, 9: address split.
- `CAS_LATENCY`, 2: CAS latency in clocks; only 2 or 3 are legal.
- `T_INIT`, 20000: power-up wait in clocks (200 µs at 100 MHz).
- `T_RP`, 2; `T_RCD`, 2; `T_RFC`, 7; `T_MRD`, 2; `T_WR`, 2: timing in clocks.
- `T_REFI`, 780: clocks between automatic refreshes.
- `clk` in 1: SDRAM clock, same clock as the `sdram_bus` instance.
- `rst` in 1: synchronous, active-high reset.
- `read_buf` in 1: synchronised read request level.
- `write_buf` in 1: synchronised write request level.
- `address` in ADDR_BITS: word address, `{bank,row,col}`.
- `data_write` in DATA_BITS: write data.
- `refresh_buf` in 1: one-cycle forced-refresh pulse.
- `data_read` out DATA_BITS: last read word.
- `busy` out 1: controller not ready for a new request.
- `sdram_cke`, `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: SDRAM control pins.
- `sdram_ba` out BANK_BITS: bank address.
- `sdram_addr` out ROW_BITS: row/column/mode address.
- `sdram_dqm` out DATA_BITS/8: byte masks; always 0 after init.
- `sdram_dq_o` out DATA_BITS: DQ output data.
- `sdram_dq_oe` out 1: DQ output enable.
- `sdram_dq_i` in DATA_BITS: DQ input data; the tri-state buffer sits at top level.

## Operation
- Requests are rising edges of `read_buf` or `write_buf`, detected internally against a 1-cycle delayed copy.
  - Levels held high never retrigger.
  - Edges arriving while `busy`=1 are dropped. The host must wait for `busy`=0.
  - Simultaneous read and write edges: the read is executed and the write is dropped.
- `address` and `data_write` are captured on the request-accept cycle.
- States:
  - Init path: INIT_WAIT → INIT_PRE → INIT_REF1 → INIT_REF2 → INIT_MODE → IDLE.
  - Access and refresh: IDLE → ACTIVATE → RW → PRECHARGE_WAIT → IDLE, and IDLE → REFRESH → IDLE.
  - One down-counter is loaded with the wait for each state.
- Init sequence:
  - Hold NOP with CKE=1 for `T_INIT` clocks.
  - PRECHARGE ALL (A10=1), then wait `T_RP`.
  - AUTO REFRESH twice, each followed by `T_RFC`.
  - LOAD MODE with burst length 1, sequential, CL=`CAS_LATENCY`, A9=0; then wait `T_MRD`.
- Refresh counter:
  - Counts `T_REFI` down from the end of init.
  - Reaching 0 or a `refresh_buf` pulse sets `ref_pending`.
  - `ref_pending` is served from IDLE before any request. An edge arriving that cycle is latched and executed afterward.
  - The counter reloads when the REFRESH command issues.
- Read: ACTIVATE (row, bank); wait `T_RCD`; READ with A10=1 (auto-precharge). Data is captured from `sdram_dq_i` exactly `CAS_LATENCY` cycles after the READ command.
- Write: ACTIVATE; wait `T_RCD`; WRITE with A10=1 and `sdram_dq_oe`=1 for that cycle only; then wait `T_WR`+`T_RP`.
- `data_read` updates only on completed reads and holds otherwise.
- Commands not listed above are NOP (`cs_n`=0, `ras_n`/`cas_n`/`we_n`=1).

## Timing
- Reset values: `busy`=1, `data_read`=0, `sdram_cke`=0, `cs_n`/`ras_n`/`cas_n`/`we_n`=1, `ba`/`addr`=0, `dqm`=all-ones, `dq_oe`=0; state = INIT_WAIT. CKE rises one cycle after reset is released.
- `busy` stays 1 until IDLE is entered after init.
- Read, with the accept cycle as cycle 0:
  - ACTIVATE at cycle 1; READ at cycle 1+`T_RCD`.
  - `data_read` valid and `busy`=0 at cycle 1+`T_RCD`+`CAS_LATENCY`+1. With defaults, cycle 6.
- Write: WRITE at cycle 1+`T_RCD`; `busy`=0 at cycle 1+`T_RCD`+`T_WR`+`T_RP`+1. With defaults, cycle 8.
- `busy` goes to 1 in the cycle after the accepting edge is seen, or during refresh. It is registered.
- `rst` asserted mid-access: the access is abandoned the next cycle, outputs go to their reset values, and full init reruns.

## Structure
- `sdram_pkg` holds:
  - the command enum `{cs_n,ras_n,cas_n,we_n}`: NOP=0111, ACTIVE=0011, READ=0101, WRITE=0100, PRECHARGE=0010, REFRESH=0001, LOAD_MODE=0000;
  - the state enum;
  - the mode-register field helper function.
- Single module, no sub-modules. The address split is done with localparams.

## Test plan
- Reset then release → NOP for 20000 clocks, then PRECHARGE (A10=1), REFRESH, REFRESH, LOAD_MODE with addr=0x020; `busy` falls at the first IDLE.
- Write 0xA5C3 to address 0x12_3456 → ACTIVATE ba=0, row=0x091A; WRITE col=0x056 A10=1 with `dq_o`=0xA5C3 and `dq_oe`=1; `busy`=0 at cycle 8.
- Read back the same address against the SDRAM model → `data_read`=0xA5C3 with `busy`=0 at cycle 6.
- Idle for 2000 clocks → exactly 2 REFRESH commands, 780 clocks apart.
- `refresh_buf` pulse and read edge in the same cycle → REFRESH issues first; ACTIVATE follows `T_RFC` later; read data is correct.
- Assert `rst` during the RW state of a read → next cycle `busy`=1 and `cke`=0, `data_read`=0; the init sequence reruns from the start.
